// File: rtl/count_checker.sv
// count_checker: locks onto an incrementing count stream, classifies anomalies and queues event records
module count_checker #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int TALLY_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_count,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [1:0]             ev_kind,
    output logic [WIDTH-1:0]       ev_value,
    output logic                   locked,
    output logic [TALLY_WIDTH-1:0] wraps,
    output logic [TALLY_WIDTH-1:0] errors,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] K_SYNC = 2'd0, K_WRAP = 2'd1, K_RESET = 2'd2, K_MISMATCH = 2'd3;

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] expected;
    logic             push, pop, full, accept;
    logic [1:0]       kind;
    logic [1:0]       mem_kind  [DEPTH];
    logic [WIDTH-1:0] mem_value [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    // A non-matching zero with a nonzero expectation is an upstream counter reset, not an error
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        kind     = K_SYNC;
        if (in_valid) begin
            if (state == UNLOCKED) begin
                push     = 1'b1;
                state_nx = LOCKED;
            end else if (in_count == expected) begin
                push = expected == '0;
                kind = K_WRAP;
            end else begin
                push = 1'b1;
                kind = in_count == '0 ? K_RESET : K_MISMATCH;
            end
        end
    end

    assign pop      = ev_valid && ev_ready;
    assign full     = count == (AW+1)'(DEPTH);
    assign accept   = push && (!full || pop);
    assign ev_valid = count != '0;
    assign ev_kind  = ev_valid ? mem_kind[rd_ptr] : '0;
    assign ev_value = ev_valid ? mem_value[rd_ptr] : '0;
    assign locked   = state == LOCKED;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_kind[wr_ptr]  <= kind;
            mem_value[wr_ptr] <= in_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNLOCKED;
            expected <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wraps    <= '0;
            errors   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (in_valid) expected <= in_count + 1'b1;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(accept) - (AW+1)'(pop);
            if (push && !accept) overflow <= 1'b1;
            if (push && kind == K_WRAP && wraps != '1) wraps <= wraps + 1'b1;
            if (push && kind == K_MISMATCH && errors != '1) errors <= errors + 1'b1;
        end
    end
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: randomized and directed checks of count_checker against a queue-based reference model
module tb_count_checker;
    localparam int DEPTH = 4;
    localparam int SYNC = 0, WRAP = 1, RST_EV = 2, MISM = 3;

    typedef struct {int kind; int value;} rec_t;

    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, ev_ready = 1'b0;
    logic [7:0] in_count = '0;
    logic       ev_valid, locked, overflow;
    logic [1:0] ev_kind;
    logic [7:0] ev_value, wraps, errors;

    int   passed = 0, total = 0;
    rec_t q[$];
    bit   m_locked, m_ovf;
    int   m_exp, m_wraps, m_errs;

    count_checker #(.WIDTH(8), .DEPTH(DEPTH), .TALLY_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_value(ev_value),
        .locked(locked), .wraps(wraps), .errors(errors), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        q.delete();
        m_locked = 0; m_ovf = 0; m_exp = 0; m_wraps = 0; m_errs = 0;
    endtask

    // Applies the classification rules to one edge's inputs
    task automatic model_edge(input bit v, input int c, input bit r);
        bit do_pop = q.size() > 0 && r;
        bit was_full = q.size() == DEPTH;
        int k = -1;
        if (v) begin
            if (!m_locked) k = SYNC;
            else if (c == m_exp) k = (m_exp == 0) ? WRAP : -1;
            else if (c == 0) k = RST_EV;
            else k = MISM;
            m_locked = 1;
            m_exp = (c + 1) % 256;
            if (k == WRAP && m_wraps < 255) m_wraps++;
            if (k == MISM && m_errs < 255) m_errs++;
        end
        if (do_pop) void'(q.pop_front());
        if (k >= 0) begin
            if (!was_full || do_pop) q.push_back('{k, c});
            else m_ovf = 1;
        end
    endtask

    task automatic step(input bit v, input int c, input bit r);
        in_valid = v; in_count = 8'(c); ev_ready = r;
        @(posedge clk);
        model_edge(v, c, r);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; in_valid = 1'b1; in_count = 8'($urandom); ev_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset(2);
        total++; if (ev_valid !== 1'b0) $display("FAIL reset ev_valid got %b want 0", ev_valid); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL reset locked got %b want 0", locked); else passed++;
        total++; if ({ev_kind, ev_value} !== 10'd0) $display("FAIL reset head got %0d/%0h want 0/0", ev_kind, ev_value); else passed++;
        total++; if ({wraps, errors, overflow} !== 17'd0) $display("FAIL reset tallies got %0d/%0d/%b want 0/0/0", wraps, errors, overflow); else passed++;
    endtask

    task automatic test_sync();
        int syncs = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, i, 1);
            if (ev_valid && ev_kind == 2'(SYNC)) syncs++;
            if (i == 0) begin
                total++; if ({ev_valid, ev_kind, ev_value} !== {1'b1, 2'd0, 8'd0}) $display("FAIL sync head got %b/%0d/%0h want 1/0/0", ev_valid, ev_kind, ev_value); else passed++;
                total++; if (locked !== 1'b1) $display("FAIL sync locked got %b want 1", locked); else passed++;
            end
        end
        total++; if (syncs != 1) $display("FAIL sync count got %0d want 1", syncs); else passed++;
        total++; if ({wraps, errors, ev_valid} !== 17'd0) $display("FAIL sync tallies got %0d/%0d/%b want 0/0/0", wraps, errors, ev_valid); else passed++;
    endtask

    task automatic test_wrap();
        int s[5] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
        int nw = 0, nm = 0;
        do_reset(1);
        foreach (s[i]) begin
            step(1, s[i], 1);
            if (ev_valid && ev_kind == 2'(WRAP)) begin
                nw++;
                total++; if (ev_value !== 8'h00) $display("FAIL wrap value got %0h want 0", ev_value); else passed++;
            end
            if (ev_valid && ev_kind == 2'(MISM)) nm++;
        end
        total++; if (nw != 1 || nm != 0) $display("FAIL wrap events got %0d/%0d want 1/0", nw, nm); else passed++;
        total++; if (wraps !== 8'd1 || errors !== 8'd0) $display("FAIL wrap tallies got %0d/%0d want 1/0", wraps, errors); else passed++;
    endtask

    task automatic test_mismatch();
        int s[4] = '{5, 6, 9, 10};
        int nm = 0, other = 0;
        do_reset(1);
        foreach (s[i]) begin
            step(1, s[i], 1);
            if (ev_valid && ev_kind == 2'(MISM)) begin
                nm++;
                total++; if (ev_value !== 8'd9) $display("FAIL mismatch value got %0d want 9", ev_value); else passed++;
            end else if (ev_valid && i > 0) other++;
        end
        total++; if (nm != 1 || other != 0) $display("FAIL mismatch events got %0d/%0d want 1/0", nm, other); else passed++;
        total++; if (errors !== 8'd1) $display("FAIL mismatch errors got %0d want 1", errors); else passed++;
    endtask

    task automatic test_reset_event();
        int s[4] = '{8'h40, 8'h41, 8'h00, 8'h01};
        int nr = 0;
        do_reset(1);
        foreach (s[i]) begin
            step(1, s[i], 1);
            if (ev_valid && ev_kind == 2'(RST_EV)) begin
                nr++;
                total++; if (ev_value !== 8'h00) $display("FAIL rstev value got %0h want 0", ev_value); else passed++;
            end
        end
        total++; if (nr != 1) $display("FAIL rstev count got %0d want 1", nr); else passed++;
        total++; if (errors !== 8'd0) $display("FAIL rstev errors got %0d want 0", errors); else passed++;
    endtask

    task automatic test_overflow();
        do_reset(1);
        step(1, 0, 1);
        step(0, 0, 1);
        for (int i = 1; i <= 5; i++) begin
            step(1, 10 * i, 0);
            total++; if ({ev_valid, ev_kind, ev_value} !== {1'b1, 2'd3, 8'd10}) $display("FAIL ovf hold got %b/%0d/%0d want 1/3/10", ev_valid, ev_kind, ev_value); else passed++;
            total++; if (overflow !== (i == 5)) $display("FAIL ovf flag step %0d got %b want %b", i, overflow, i == 5); else passed++;
        end
        total++; if (errors !== 8'd5) $display("FAIL ovf errors got %0d want 5", errors); else passed++;
        for (int i = 1; i <= 4; i++) begin
            total++; if ({ev_valid, ev_value} !== {1'b1, 8'(10 * i)}) $display("FAIL ovf drain %0d got %b/%0d want 1/%0d", i, ev_valid, ev_value, 10 * i); else passed++;
            step(0, 0, 1);
        end
        total++; if (ev_valid !== 1'b0 || overflow !== 1'b1) $display("FAIL ovf after drain got %b/%b want 0/1", ev_valid, overflow); else passed++;
    endtask

    task automatic test_back_to_back();
        int want[4] = '{20, 30, 40, 60};
        do_reset(1);
        step(1, 0, 1);
        step(0, 0, 1);
        for (int i = 1; i <= 4; i++) step(1, 10 * i, 0);
        step(1, 60, 1);
        total++; if (overflow !== 1'b0 || errors !== 8'd5) $display("FAIL b2b flags got %b/%0d want 0/5", overflow, errors); else passed++;
        foreach (want[i]) begin
            total++; if ({ev_valid, ev_value} !== {1'b1, 8'(want[i])}) $display("FAIL b2b drain %0d got %b/%0d want 1/%0d", i, ev_valid, ev_value, want[i]); else passed++;
            step(0, 0, 1);
        end
        total++; if (ev_valid !== 1'b0) $display("FAIL b2b empty got %b want 0", ev_valid); else passed++;
        step(1, 3, 0);
        step(1, 7, 0);
        do_reset(1);
        total++; if ({ev_valid, locked, wraps, errors, overflow} !== 19'd0) $display("FAIL midreset got %b/%b/%0d/%0d/%b want all 0", ev_valid, locked, wraps, errors, overflow); else passed++;
    endtask

    task automatic test_saturate();
        do_reset(1);
        step(1, 255, 1);
        for (int i = 0; i < 260; i++) begin
            step(1, 0, 1);
            step(1, 255, 1);
        end
        total++; if (wraps !== 8'(m_wraps) || wraps !== 8'd255) $display("FAIL sat wraps got %0d want 255", wraps); else passed++;
        total++; if (errors !== 8'(m_errs) || errors !== 8'd255) $display("FAIL sat errors got %0d want 255", errors); else passed++;
    endtask

    task automatic test_random();
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            int sel = $urandom_range(0, 9);
            int c = sel < 6 ? m_exp : (sel == 6 ? 0 : $urandom_range(0, 255));
            step(($urandom % 4) != 0, c, ($urandom % 3) != 0);
            total++; if (ev_valid !== (q.size() > 0)) $display("FAIL rand ev_valid %0d got %b want %b", i, ev_valid, q.size() > 0); else passed++;
            if (q.size() > 0) begin
                total++; if (ev_kind !== 2'(q[0].kind) || ev_value !== 8'(q[0].value)) $display("FAIL rand head %0d got %0d/%0h want %0d/%0h", i, ev_kind, ev_value, q[0].kind, q[0].value); else passed++;
            end
            total++; if (locked !== m_locked || overflow !== m_ovf) $display("FAIL rand flags %0d got %b/%b want %b/%b", i, locked, overflow, m_locked, m_ovf); else passed++;
            total++; if (wraps !== 8'(m_wraps) || errors !== 8'(m_errs)) $display("FAIL rand tallies %0d got %0d/%0d want %0d/%0d", i, wraps, errors, m_wraps, m_errs); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_wrap();
        test_mismatch();
        test_reset_event();
        test_overflow();
        test_back_to_back();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
